// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode, funct and ALU encodings for the multicycle MIPS controller
package mips_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH   = 4'd0;
  localparam state_t S_DECODE  = 4'd1;
  localparam state_t S_MEMADR  = 4'd2;
  localparam state_t S_MEMRD   = 4'd3;
  localparam state_t S_MEMWB   = 4'd4;
  localparam state_t S_MEMWR   = 4'd5;
  localparam state_t S_EXECUTE = 4'd6;
  localparam state_t S_ALUWB   = 4'd7;
  localparam state_t S_BRANCH  = 4'd8;
  localparam state_t S_ADDIEX  = 4'd9;
  localparam state_t S_ADDIWB  = 4'd10;
  localparam state_t S_JUMP    = 4'd11;
  localparam state_t S_TRAP    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// rtl/mips_multicycle_controller_alu_decoder.sv - ALU operation decode from aluop and funct
module ALU_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: aluControl = ALU_ADD;
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluControl = ALU_ADD;
          FN_SUB:  aluControl = ALU_SUB;
          FN_AND:  aluControl = ALU_AND;
          FN_OR:   aluControl = ALU_OR;
          FN_SLT:  aluControl = ALU_SLT;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - Moore FSM controller for a multicycle MIPS datapath
module mips_multicycle_controller
  import mips_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state_q, state_d;
  logic   supported;
  logic   pcwrite, branch, irwrite_raw, memwrite_raw, regwrite_raw, done_raw;

  assign supported = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                     (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    iord = 1'b0; irwrite_raw = 1'b0; memwrite_raw = 1'b0; regwrite_raw = 1'b0;
    pcwrite = 1'b0; branch = 1'b0; regdst = 1'b0; memtoreg = 1'b0;
    alusrca = 1'b0; alusrcb = 2'b00; pcsrc = 2'b00; aluop = ALUOP_ADD; done_raw = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01; irwrite_raw = 1'b1; pcwrite = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1; alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord = 1'b1; memwrite_raw = 1'b1; done_raw = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1; regwrite_raw = 1'b1; done_raw = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1; aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst = 1'b1; regwrite_raw = 1'b1; done_raw = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1; done_raw = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; branch = 1'b1; done_raw = 1'b1;
      end
      S_JUMP: begin
        pcsrc = 2'b10; pcwrite = 1'b1; done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables and pulses are masked by reset_n so nothing commits while reset is held.
  assign irwrite    = irwrite_raw & reset_n;
  assign memwrite   = memwrite_raw & reset_n;
  assign regwrite   = regwrite_raw & reset_n;
  assign pcen       = (pcwrite | (branch & zero)) & reset_n;
  assign instr_done = done_raw & reset_n;
  assign illegal_op = (state_q == S_DECODE) & ~supported & reset_n;
  assign state      = state_q;

  ALU_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .aluControl (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - directed self-checking bench for mips_multicycle_controller
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero;

  logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  logic       t_iord, t_memwrite, t_irwrite, t_pcen, t_regdst, t_memtoreg, t_regwrite, t_alusrca;
  logic [1:0] t_alusrcb, t_pcsrc, t_aluop;
  logic [2:0] t_alucontrol;
  logic [3:0] t_state;
  logic       t_instr_done, t_illegal_op;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] cap_state [0:7];
  logic       cap_rw [0:7], cap_mtr [0:7], cap_mw [0:7], cap_pcen [0:7], cap_done [0:7], cap_ill [0:7];
  logic [2:0] cap_alc [0:7];
  logic [1:0] cap_pcsrc [0:7];

  always #5 clk = ~clk;

  mips_multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .alucontrol(alucontrol), .state(state),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  mips_multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .iord(t_iord), .memwrite(t_memwrite), .irwrite(t_irwrite), .pcen(t_pcen), .regdst(t_regdst),
    .memtoreg(t_memtoreg), .regwrite(t_regwrite), .alusrca(t_alusrca), .alusrcb(t_alusrcb),
    .pcsrc(t_pcsrc), .aluop(t_aluop), .alucontrol(t_alucontrol), .state(t_state),
    .instr_done(t_instr_done), .illegal_op(t_illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge in FETCH; captures n cycles and returns at the negedge after the last one.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
    opcode = op; funct = fn; zero = z;
    #1;
    for (int c = 0; c < n; c++) begin
      cap_state[c] = state;  cap_rw[c] = regwrite;  cap_mtr[c] = memtoreg;
      cap_mw[c] = memwrite;  cap_pcen[c] = pcen;     cap_done[c] = instr_done;
      cap_ill[c] = illegal_op; cap_alc[c] = alucontrol; cap_pcsrc[c] = pcsrc;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [3:0]  exp_seq [0:4];
  logic [5:0]  r_funct [0:4];
  logic [2:0]  r_alc   [0:4];

  initial begin
    reset_n = 1'b0; opcode = 6'b100011; funct = 6'b0; zero = 1'b0;
    r_funct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    r_alc   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    #2;
    check("rst_state", state, 4'd0);
    check("rst_irwrite", irwrite, 0);
    check("rst_pcen", pcen, 0);
    check("rst_memwrite", memwrite, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_done", instr_done, 0);
    check("rst_alusrcb", alusrcb, 2'b01);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("fetch_irwrite", irwrite, 1);
    check("fetch_pcen", pcen, 1);

    // lw: 5 cycles, register write only in the last
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    run(6'b100011, 6'b0, 1'b0, 5);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("lw_state%0d", c), cap_state[c], exp_seq[c]);
      check($sformatf("lw_regwrite%0d", c), cap_rw[c], (c == 4));
      check($sformatf("lw_memtoreg%0d", c), cap_mtr[c], (c == 4));
      check($sformatf("lw_done%0d", c), cap_done[c], (c == 4));
    end
    check("lw_back_fetch", state, 4'd0);

    for (int i = 0; i < 5; i++) begin
      run(6'b000000, r_funct[i], 1'b0, 4);
      check($sformatf("r%0d_exec_state", i), cap_state[2], 4'd6);
      check($sformatf("r%0d_alucontrol", i), cap_alc[2], r_alc[i]);
      check($sformatf("r%0d_aluwb_state", i), cap_state[3], 4'd7);
      check($sformatf("r%0d_aluwb_regwrite", i), cap_rw[3], 1);
    end

    run(6'b001000, 6'b0, 1'b0, 4);
    check("addi_ex_state", cap_state[2], 4'd9);
    check("addi_wb_state", cap_state[3], 4'd10);
    check("addi_wb_regwrite", cap_rw[3], 1);
    check("addi_wb_memtoreg", cap_mtr[3], 0);

    run(6'b000100, 6'b0, 1'b1, 3);
    check("beq1_state", cap_state[2], 4'd8);
    check("beq1_pcen", cap_pcen[2], 1);
    check("beq1_alucontrol", cap_alc[2], 3'b110);
    check("beq1_back_fetch", state, 4'd0);
    run(6'b000100, 6'b0, 1'b0, 3);
    check("beq0_state", cap_state[2], 4'd8);
    check("beq0_pcen", cap_pcen[2], 0);
    check("beq0_back_fetch", state, 4'd0);

    run(6'b000010, 6'b0, 1'b0, 3);
    check("j_state", cap_state[2], 4'd11);
    check("j_pcsrc", cap_pcsrc[2], 2'b10);
    check("j_pcen", cap_pcen[2], 1);
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    run(6'b101011, 6'b0, 1'b0, 4);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("sw_state%0d", c), cap_state[c], exp_seq[c]);
      check($sformatf("sw_memwrite%0d", c), cap_mw[c], (c == 3));
    end

    run(6'b111111, 6'b0, 1'b0, 2);
    check("ill_decode_state", cap_state[1], 4'd1);
    check("ill_pulse", cap_ill[1], 1);
    check("ill_no_pulse_fetch", cap_ill[0], 0);
    check("ill_back_fetch", state, 4'd0);
    check("trap_entered", t_state, 4'd12);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("trap_state%0d", c), t_state, 4'd12);
      check($sformatf("trap_we%0d", c), {t_irwrite, t_pcen, t_memwrite, t_regwrite}, 4'b0000);
      @(negedge clk);
    end
    check("ill_repeat_state", state inside {4'd0, 4'd1}, 1);

    do_reset();
    opcode = 6'b101011; funct = 6'b0; zero = 1'b0;
    #1;
    check("realign_state", state, 4'd0);
    check("realign_trap_state", t_state, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("memwr_state", state, 4'd5);
    check("memwr_memwrite", memwrite, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_state", state, 4'd0);
    check("async_rst_memwrite", memwrite, 0);
    check("async_rst_irwrite", irwrite, 0);
    check("async_rst_pcen", pcen, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
MIPS_MULTICYCLE_CONTROLLER -- requirements
Module: mips_multicycle_controller

Interface
REQ-001 SHALL have parameter ILLEGAL_TRAP, default 0, meaning 1 = lock in TRAP on an unsupported opcode, 0 = report it and resume FETCH.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  6  instruction register bits 31:26.
REQ-005 SHALL have port funct  input  6  instruction register bits 5:0.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have ports iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca, each an output of width 1, all standard multicycle MIPS datapath controls.
REQ-008 SHALL have ports alusrcb  output  2, pcsrc  output  2 and aluop  output  2.
REQ-009 SHALL have port alucontrol  output  3  ALU operation: ADD 010, SUB 110, AND 000, OR 001, SLT 111.
REQ-010 SHALL have port state  output  4  current state, for debug.
REQ-011 SHALL have port instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-012 SHALL have port illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-013 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP and TRAP.
REQ-014 SHALL sequence FETCH to DECODE unconditionally.
REQ-015 SHALL leave DECODE by opcode: lw 100011 and sw 101011 to MEMADR; R-type 000000 to EXECUTE; beq 000100 to BRANCH; addi 001000 to ADDIEX; j 000010 to JUMP.
REQ-016 SHALL, on any other opcode in DECODE, go to TRAP when ILLEGAL_TRAP=1 and to FETCH otherwise, and pulse illegal_op in either case.
REQ-017 SHALL sequence MEMADR to MEMRD for lw and to MEMWR for sw, MEMRD to MEMWB, and EXECUTE to ALUWB.
REQ-018 SHALL sequence ADDIEX to ADDIWB, and MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP each to FETCH.
REQ-019 SHALL hold TRAP until reset.
REQ-020 SHALL give instruction latencies, FETCH to last state inclusive: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
REQ-021 SHALL, in FETCH, drive iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1 and pcwrite=1.
REQ-022 SHALL drive, in DECODE, alusrca=0, alusrcb=11, aluop=00.
REQ-023 SHALL drive alusrca=1, alusrcb=10, aluop=00 in MEMADR and in ADDIEX.
REQ-024 SHALL drive iord=1 in MEMRD, and iord=1 with memwrite=1 in MEMWR.
REQ-025 SHALL drive regdst=0, memtoreg=1, regwrite=1 in MEMWB.
REQ-026 SHALL drive alusrca=1, alusrcb=00, aluop=10 in EXECUTE.
REQ-027 SHALL drive regdst=1, memtoreg=0, regwrite=1 in ALUWB.
REQ-028 SHALL drive regdst=0, memtoreg=0, regwrite=1 in ADDIWB.
REQ-029 SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01 and branch=1 in BRANCH.
REQ-030 SHALL drive pcsrc=10 and pcwrite=1 in JUMP.
REQ-031 SHALL drive every unlisted control to 0 in every state, and all write enables to 0 in TRAP.
REQ-032 SHALL compute pcen = pcwrite | (branch & zero), combinationally within the same cycle.
REQ-033 SHALL derive alucontrol combinationally from aluop and funct: aluop 00 gives ADD, 01 gives SUB, 10 decodes funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, others ADD).

Reset
REQ-034 SHALL force state to FETCH immediately and asynchronously while reset_n=0, without waiting for a clock edge.
REQ-035 SHALL hold irwrite, pcen, memwrite, regwrite, instr_done and illegal_op at 0 while reset_n=0, with all other outputs at their FETCH values.
REQ-036 SHALL, when reset asserts mid-instruction, abandon that instruction with no further write-enable asserted.
REQ-037 SHALL leave the first FETCH cycle at the first rising clk edge after reset_n rises.

Structure
REQ-038 SHALL take the state enum, opcode constants, funct constants, aluop codes and alucontrol codes from shared package mips_pkg.
REQ-039 SHALL instantiate the existing ALU_decoder as its only sub-module, with ports aluop, funct and aluControl.

Verification
REQ-040 SHALL verify lw (opcode 100011): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, with regwrite=1 and memtoreg=1 only in cycle 5 and instr_done in cycle 5.
REQ-041 SHALL verify R-type add, sub, and, or, slt (funct 100000, 100010, 100100, 100101, 101010): in EXECUTE, alucontrol = 010, 110, 000, 001, 111 respectively.
REQ-042 SHALL verify beq with zero=1: pcen=1 in BRANCH; with zero=0, pcen=0 in BRANCH; both cases return to FETCH afterward.
REQ-043 SHALL verify illegal opcode 111111: with ILLEGAL_TRAP=0, illegal_op pulses and the FSM returns to FETCH; with ILLEGAL_TRAP=1, it stays in TRAP with all write enables 0 for at least 10 cycles.
REQ-044 SHALL verify reset_n driven low mid-MEMWR: state becomes FETCH and memwrite becomes 0 before the next clk edge.
REQ-045 SHALL verify back-to-back j then sw: pcsrc=10 in JUMP, memwrite=1 only in the fourth sw cycle, and no idle cycles between the two instructions.
